// File: rtl/mux_rr_nto1.sv
// N-to-1 registered multiplexer with fixed-select or round-robin arbitration.
// A single output register holds one word, so a new word is taken whenever that register is free.
module mux_rr_nto1 #(
    parameter int SIZE = 32,
    parameter int N    = 4,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                mode,
    input  logic [SELW-1:0]     select,
    input  logic [N-1:0]        dato_valid,
    input  logic [N*SIZE-1:0]   dato,
    output logic [N-1:0]        dato_ready,
    output logic [SIZE-1:0]     salida,
    output logic                salida_valid,
    input  logic                salida_ready,
    output logic [SELW-1:0]     salida_ch
);

    logic [SIZE-1:0] r_salida;
    logic            r_valid;
    logic [SELW-1:0] r_ch;
    logic [SELW-1:0] r_ptr;

    logic            w_free;
    logic            w_cand;
    logic            w_take;
    logic [SELW-1:0] w_gidx;
    logic [SELW-1:0] w_next_ptr;
    logic [SIZE-1:0] w_word;
    int              w_idx;

    assign w_free = !r_valid || salida_ready;

    // Candidate search; an out-of-range select matches no channel.
    always_comb begin
        w_cand = 1'b0;
        w_gidx = '0;
        w_idx  = 0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (select == SELW'(i) && dato_valid[i]) begin
                    w_cand = 1'b1;
                    w_gidx = SELW'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= N) begin
                    w_idx = w_idx - N;
                end
                if (!w_cand && dato_valid[SELW'(w_idx)]) begin
                    w_cand = 1'b1;
                    w_gidx = SELW'(w_idx);
                end
            end
        end
    end

    assign w_take     = w_cand && w_free && !RESET;
    assign w_next_ptr = (int'(w_gidx) == N - 1) ? '0 : w_gidx + SELW'(1);

    always_comb begin
        w_word = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gidx == SELW'(i)) begin
                w_word = dato[i*SIZE +: SIZE];
            end
        end
    end

    always_comb begin
        dato_ready = '0;
        if (w_take) begin
            dato_ready[w_gidx] = 1'b1;
        end
    end

    // A grant takes priority over the drain, which keeps valid high on back-to-back words.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_salida <= '0;
            r_valid  <= 1'b0;
            r_ch     <= '0;
            r_ptr    <= '0;
        end else if (w_take) begin
            r_salida <= w_word;
            r_ch     <= w_gidx;
            r_valid  <= 1'b1;
            if (mode) begin
                r_ptr <= w_next_ptr;
            end
        end else if (r_valid && salida_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign salida       = r_salida;
    assign salida_valid = r_valid;
    assign salida_ch    = r_ch;

endmodule
